// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences accumulator clear, lockstep weight/activation SRAM reads and array drain; ports: start/abort/k_len/bases in, SRAM enable+addresses, array clear/valid, busy, cycles_count, compute_done out
module systolic_ctrl #(
  parameter int ROWS     = 8,
  parameter int COLS     = 4,
  parameter int ADDR_W   = 6,
  parameter int K_W      = 7,
  parameter int SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wt_base,
  output logic              sram_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              array_clear,
  output logic              array_valid,
  output logic              busy,
  output logic [5:0]        cycles_count,
  output logic              compute_done
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} state_e;
  localparam int DRAIN_LEN = SRAM_LAT + ROWS + COLS - 2;
  localparam int K_MAX     = 1 << ADDR_W;
  localparam int IW        = $clog2(K_MAX > DRAIN_LEN ? K_MAX : DRAIN_LEN) + 1;
  state_e              state_q, state_d;
  logic [IW-1:0]       k_q, k_d, idx_q, idx_d, k_eff;
  logic [ADDR_W-1:0]   act_q, act_d, wt_q, wt_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [SRAM_LAT-1:0] vld_q, vld_d;
  logic                go;
  assign go    = start && (state_q == IDLE || state_q == DONE);
  assign k_eff = int'(k_len) > K_MAX ? IW'(K_MAX) : IW'(k_len);
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? CLEAR : state_q;
      CLEAR:      state_d = abort ? IDLE : (k_q == '0 ? DONE : LOAD);
      LOAD:       state_d = abort ? IDLE : (idx_q == k_q - IW'(1) ? DRAIN : LOAD);
      DRAIN:      state_d = abort ? IDLE : (idx_q == IW'(DRAIN_LEN - 1) ? DONE : DRAIN);
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    sram_en      = state_q == LOAD;
    array_clear  = state_q == CLEAR;
    busy         = sram_en || array_clear || state_q == DRAIN;
    compute_done = state_q == DONE;
  end
  // idx counts cycles within LOAD or DRAIN and restarts whenever the state changes
  always_comb begin
    k_d   = go ? k_eff : k_q;
    idx_d = (state_d == state_q && (state_q == LOAD || state_q == DRAIN)) ? idx_q + IW'(1) : '0;
    act_d = go ? act_base : (state_q == LOAD && state_d == LOAD) ? act_q + ADDR_W'(1) : act_q;
    wt_d  = go ? wt_base : (state_q == LOAD && state_d == LOAD) ? wt_q + ADDR_W'(1) : wt_q;
    cnt_d = state_d == CLEAR ? 6'd1 :
            ((state_d == LOAD || state_d == DRAIN) && cnt_q != 6'd63) ? cnt_q + 6'd1 : cnt_q;
    vld_d = (abort && busy) ? '0 : SRAM_LAT'({vld_q, sram_en});
  end
  always_ff @(posedge clk)
    if (reset) begin
      k_q   <= '0;
      idx_q <= '0;
      act_q <= '0;
      wt_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      k_q   <= k_d;
      idx_q <= idx_d;
      act_q <= act_d;
      wt_q  <= wt_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  assign act_addr     = act_q;
  assign wt_addr      = wt_q;
  assign cycles_count = cnt_q;
  assign array_valid  = vld_q[SRAM_LAT-1];
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed scoreboard bench for systolic_ctrl
module tb_systolic_ctrl;
  logic       clk = 0, reset = 1, start = 0, abort = 0;
  logic [6:0] k_len = 0;
  logic [5:0] act_base = 0, wt_base = 0;
  logic       sram_en, array_clear, array_valid, busy, compute_done;
  logic [5:0] act_addr, wt_addr, cycles_count;
  int         total = 0, passed = 0, en_cnt = 0, n0;
  logic [11:0] q[$];

  systolic_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_len(k_len),
    .act_base(act_base), .wt_base(wt_base), .sram_en(sram_en), .act_addr(act_addr),
    .wt_addr(wt_addr), .array_clear(array_clear), .array_valid(array_valid),
    .busy(busy), .cycles_count(cycles_count), .compute_done(compute_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // advance one cycle, then check array_valid against the prior enable and pop SRAM reads
  task automatic tick();
    logic ev;
    logic [11:0] e;
    ev = (reset || abort) ? 1'b0 : (sram_en === 1'b1);
    @(posedge clk);
    #1;
    chk("array_valid", array_valid, ev);
    if (sram_en === 1'b1) begin
      en_cnt++;
      if (q.size() == 0) chk("sram_en_unexpected", sram_en, 0);
      else begin
        e = q.pop_front();
        chk("addr", {act_addr, wt_addr}, e);
      end
    end
  endtask

  task automatic go(input int k, input logic [5:0] ab, input logic [5:0] wb);
    for (int i = 0; i < (k > 64 ? 64 : k); i++) q.push_back({6'(ab + i), 6'(wb + i)});
    k_len = 7'(k);
    act_base = ab;
    wt_base = wb;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (compute_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", compute_done, 1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_sram_en", sram_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear", array_clear, 0);
    chk("rst_done", compute_done, 0);
    chk("rst_cnt", cycles_count, 0);
    chk("rst_addr", {act_addr, wt_addr}, 0);
    reset = 0;
    tick();
    go(4, 0, 0);
    for (int c = 1; c <= 18; c++) begin
      chk("t1_clear", array_clear, c == 1);
      chk("t1_sram_en", sram_en, c >= 2 && c <= 5);
      chk("t1_valid", array_valid, c >= 3 && c <= 6);
      chk("t1_busy", busy, c >= 1 && c <= 16);
      chk("t1_done", compute_done, c >= 17);
      if (c < 18) tick();
    end
    chk("t1_cnt", cycles_count, 16);
    chk("t1_q_empty", q.size(), 0);
    go(3, 62, 10);
    chk("restart_done_low", compute_done, 0);
    chk("restart_clear", array_clear, 1);
    wait_done(40);
    chk("wrap_cnt", cycles_count, 15);
    chk("wrap_q_empty", q.size(), 0);
    go(0, 5, 5);
    chk("k0_clear", array_clear, 1);
    chk("k0_cnt_clear", cycles_count, 1);
    tick();
    chk("k0_done", compute_done, 1);
    chk("k0_cnt", cycles_count, 1);
    chk("k0_busy", busy, 0);
    chk("k0_sram_en", sram_en, 0);
    n0 = en_cnt;
    go(100, 0, 0);
    wait_done(200);
    chk("clamp_en_cycles", en_cnt - n0, 64);
    chk("clamp_cnt_sat", cycles_count, 63);
    chk("clamp_q_empty", q.size(), 0);
    go(8, 0, 0);
    tick();
    tick();
    abort = 1;
    start = 1;
    tick();
    start = 0;
    chk("abort_sram_en", sram_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_clear", array_clear, 0);
    chk("abort_done", compute_done, 0);
    chk("abort_cnt_hold", cycles_count, 3);
    chk("abort_reads_consumed", q.size(), 6);
    q.delete();
    tick();
    abort = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("abort_no_done", compute_done, 0);
    chk("abort_idle", busy, 0);
    go(2, 7, 7);
    wait_done(40);
    chk("after_abort_cnt", cycles_count, 14);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_in_done_ignored", compute_done, 1);
    go(3, 1, 2);
    tick();
    start = 1;
    tick();
    chk("start_in_load_clear", array_clear, 0);
    chk("start_in_load_en", sram_en, 1);
    tick();
    chk("start_in_load_en2", sram_en, 1);
    start = 0;
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_en", sram_en, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", sram_en, 0);
    chk("mid_rst_valid", array_valid, 0);
    chk("mid_rst_done", compute_done, 0);
    chk("mid_rst_cnt", cycles_count, 0);
    chk("mid_rst_addr", {act_addr, wt_addr}, 0);
    tick();
    chk("mid_rst_no_done", compute_done, 0);
    go(1, 0, 0);
    wait_done(40);
    chk("post_rst_cnt", cycles_count, 13);
    go(0, 0, 0);
    chk("done_start_done_low", compute_done, 0);
    chk("done_start_clear", array_clear, 1);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
